// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer: owns the PC, issues one outstanding imem
// request at a time, and hands each fetched word with its PC and sliced
// decode fields to the decode stage. Redirects from execute override the
// PC and squash whatever fetch or held instruction is in progress.
//
// state | meaning
// ------+-------------------------------------------------------------
// BOOT  | first cycle after reset release, no request, redirect ignored
// REQ   | imem_req_valid high, presenting pc on imem_addr
// WAIT  | request accepted, waiting for the response strobe
// HOLD  | inst_valid high, holding inst/inst_pc until decode takes it
module instruction_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [6:0]        opcode,
  output logic [2:0]        fun3,
  output logic              fun7
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t            state;
  logic [ADDR_W-1:0] pc;
  // drop marks an in-flight request whose response must be discarded
  logic              drop;
  logic [ADDR_W-1:0] target;

  assign target = redirect_pc & ALIGN_MASK;

  // Handshake outputs come straight from the state register only.
  assign imem_req_valid = (state == REQ);
  assign inst_valid     = (state == HOLD);
  assign imem_addr      = pc;
  assign opcode         = inst[6:0];
  assign fun3           = inst[14:12];
  assign fun7           = inst[30];

  // Fetch sequencer: state, pc, drop flag and the held instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= BOOT;
      pc      <= RESET_PC;
      drop    <= 1'b0;
      inst    <= '0;
      inst_pc <= '0;
    end else begin
      case (state)
        BOOT: state <= REQ;

        REQ: begin
          if (redirect_valid) begin
            pc <= target;
            // old-address request accepted this cycle is still in flight
            if (imem_req_ready) begin
              state <= WAIT;
              drop  <= 1'b1;
            end
          end else if (imem_req_ready) begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (redirect_valid) begin
            pc <= target;
            if (imem_rsp_valid) begin
              state <= REQ;
              drop  <= 1'b0;
            end else begin
              drop  <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= REQ;
            end else begin
              inst    <= imem_rsp_data;
              inst_pc <= pc;
              pc      <= pc + ADDR_W'(4);
              state   <= HOLD;
            end
          end
        end

        HOLD: begin
          // a redirect squashes the held word even if decode takes it
          if (redirect_valid) begin
            pc    <= target;
            state <= REQ;
          end else if (inst_ready) begin
            state <= REQ;
          end
        end

        default: state <= BOOT;
      endcase
    end
  end

endmodule
